// File: rtl/gb_serial_port.sv
// Serial link port behind the SB/SC IO registers: 8-bit MSB-first shifter
// clocked internally (prescaled clk) or externally (synchronized sck_in).
module gb_serial_port #(
    parameter int CLK_DIV = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_ser,
    input  logic [1:0] adr,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       sck_in,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       sin,
    output logic       sout,
    output logic       irq
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    sb;
    logic          clksel;
    logic [2:0]    cnt;
    logic [PW-1:0] presc;
    logic          sck_s1;
    logic          sck_s2;
    logic          sck_s3;
    logic          sin_s1;
    logic          sin_s2;

    logic sb_wr;
    logic sc_wr;
    logic in_shift;
    logic edge_fall;
    logic edge_rise;
    logic done;
    logic start;

    // read strobes carry no side effects; data_out is decoded from adr alone
    logic unused_read;
    assign unused_read = read;

    assign start    = (state == SHIFT);
    assign in_shift = (state == SHIFT);
    assign sck_oe   = clksel;

    always_comb begin
        sb_wr     = sel_ser & write & (adr == 2'b01);
        sc_wr     = sel_ser & write & (adr == 2'b10);
        edge_fall = 1'b0;
        edge_rise = 1'b0;
        if (in_shift) begin
            if (clksel) begin
                edge_fall = (presc == HALF);
                edge_rise = (presc == LAST);
            end else begin
                edge_fall = ~sck_s2 & sck_s3;
                edge_rise = sck_s2 & ~sck_s3;
            end
        end
        // an SC write in the completing cycle takes priority over completion
        done     = edge_rise & (cnt == 3'd7) & ~sc_wr;
        state_nx = state;
        if (sc_wr) begin
            state_nx = data_in[7] ? SHIFT : IDLE;
        end else if (done) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sb      <= 8'h00;
            clksel  <= 1'b0;
            cnt     <= 3'd0;
            presc   <= '0;
            sck_out <= 1'b1;
            sout    <= 1'b1;
            irq     <= 1'b0;
            sck_s1  <= 1'b1;
            sck_s2  <= 1'b1;
            sck_s3  <= 1'b1;
            sin_s1  <= 1'b1;
            sin_s2  <= 1'b1;
        end else begin
            sck_s1 <= sck_in;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            sin_s1 <= sin;
            sin_s2 <= sin_s1;
            irq    <= done;
            if (sc_wr) begin
                clksel  <= data_in[0];
                cnt     <= 3'd0;
                presc   <= '0;
                sck_out <= 1'b1;
            end else if (in_shift) begin
                if (clksel) begin
                    presc <= (presc == LAST) ? '0 : presc + 1'b1;
                end
                if (edge_fall) begin
                    sout <= sb[7];
                    if (clksel) begin
                        sck_out <= 1'b0;
                    end
                end
                if (edge_rise) begin
                    sb      <= {sb[6:0], sin_s2};
                    cnt     <= cnt + 3'd1;
                    sck_out <= 1'b1;
                end
            end else if (sb_wr) begin
                sb <= data_in;
            end
        end
    end

    always_comb begin
        data_out = 8'hFF;
        if (sel_ser) begin
            case (adr)
                2'b01:   data_out = sb;
                2'b10:   data_out = {start, 6'b111111, clksel};
                default: data_out = 8'hFF;
            endcase
        end
    end

endmodule
